// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: FSM encoding and
// memory address field layout.
package cache_refill_ctrl_pkg;

    localparam int unsigned TAG_W   = 1;
    localparam int unsigned INDEX_W = 1;
    localparam int unsigned WORD_W  = 1;
    localparam int unsigned ADDR_W  = TAG_W + INDEX_W + WORD_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4
    } state_t;

    // Word address presented to memory, most significant field first
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [WORD_W-1:0]  word;
    } mem_addr_t;

endpackage

// File: rtl/cache_refill_ctrl_word_reg.sv
// Single line-buffer word: synchronous clear, load on enable.
module cache_refill_ctrl_word_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Two-way cache refill controller: looks up a CPU load, on a miss fetches the
// line word by word from memory, fills the round-robin victim way and replays.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CACHE_SIZE = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_tag,
    input  logic                            req_index,
    input  logic                            req_offset,
    output logic                            resp_valid,
    input  logic                            hit,
    input  logic                            hit_0,
    input  logic                            hit_1,
    output logic                            out_tag,
    output logic                            out_index,
    output logic                            control_offset,
    output logic                            control_cache_word,
    output logic [WIDTH*CACHE_SIZE/2-1:0]   line_bus_0,
    output logic [WIDTH*CACHE_SIZE/2-1:0]   line_bus_1,
    output logic [1:0]                      is_load_bus,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [2:0]                      mem_req_addr,
    input  logic                            mem_resp_valid,
    input  logic [WIDTH-1:0]                mem_resp_data
);

    localparam int unsigned LINE_WORDS = CACHE_SIZE / 2;
    localparam int unsigned LINE_W     = WIDTH * LINE_WORDS;

    state_t              state;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  index_q;
    logic                offset_q;
    logic [WORD_W-1:0]   word_q;
    logic                victim_q;
    logic [LINE_W-1:0]   line_buf;
    logic                capture;
    logic                last_word;
    logic                in_fill;
    mem_addr_t           addr;

    assign capture   = (state == MEM_WAIT) && mem_resp_valid;
    assign last_word = (word_q == WORD_W'(LINE_WORDS - 1));
    assign in_fill   = (state == FILL);

    // Control FSM, word counter, victim pointer and request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= 1'b0;
            word_q   <= '0;
            victim_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tag_q    <= TAG_W'(req_tag);
                        index_q  <= INDEX_W'(req_index);
                        offset_q <= req_offset;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        word_q <= '0;
                        state  <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        if (last_word) begin
                            state <= FILL;
                        end else begin
                            word_q <= word_q + WORD_W'(1);
                            state  <= MEM_REQ;
                        end
                    end
                end
                FILL: begin
                    victim_q <= ~victim_q;
                    state    <= LOOKUP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line buffer: word 0 occupies the most significant slice
    for (genvar w = 0; w < LINE_WORDS; w++) begin : g_line_word
        cache_refill_ctrl_word_reg #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk (clk),
            .rst (rst),
            .en  (capture && (word_q == WORD_W'(w))),
            .d   (mem_resp_data),
            .q   (line_buf[(LINE_WORDS-1-w)*WIDTH +: WIDTH])
        );
    end

    assign addr = '{tag: tag_q, index: index_q, word: word_q};

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == MEM_REQ);
    assign mem_req_addr  = addr;
    assign out_tag       = tag_q;
    assign out_index     = index_q;

    // Hit response is same-cycle with the cache's hit flags
    assign resp_valid         = (state == LOOKUP) && hit;
    assign control_offset     = (state == LOOKUP) && offset_q;
    assign control_cache_word = (state == LOOKUP) && hit_1 && !hit_0;

    assign is_load_bus = in_fill ? (victim_q ? 2'b01 : 2'b10) : 2'b00;
    assign line_bus_0  = (in_fill && !victim_q) ? line_buf : '0;
    assign line_bus_1  = (in_fill &&  victim_q) ? line_buf : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl with a behavioural two-way cache and
// memory model; expected fills, addresses and latencies come from the model.
module tb_cache_refill_ctrl;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned CACHE_SIZE = 4;
    localparam int unsigned LINE_W     = WIDTH * CACHE_SIZE / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_tag;
    logic              req_index;
    logic              req_offset;
    logic              resp_valid;
    logic              hit;
    logic              hit_0;
    logic              hit_1;
    logic              out_tag;
    logic              out_index;
    logic              control_offset;
    logic              control_cache_word;
    logic [LINE_W-1:0] line_bus_0;
    logic [LINE_W-1:0] line_bus_1;
    logic [1:0]        is_load_bus;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [2:0]        mem_req_addr;
    logic              mem_resp_valid;
    logic [WIDTH-1:0]  mem_resp_data;

    cache_refill_ctrl #(
        .WIDTH      (WIDTH),
        .CACHE_SIZE (CACHE_SIZE)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_tag            (req_tag),
        .req_index          (req_index),
        .req_offset         (req_offset),
        .resp_valid         (resp_valid),
        .hit                (hit),
        .hit_0              (hit_0),
        .hit_1              (hit_1),
        .out_tag            (out_tag),
        .out_index          (out_index),
        .control_offset     (control_offset),
        .control_cache_word (control_cache_word),
        .line_bus_0         (line_bus_0),
        .line_bus_1         (line_bus_1),
        .is_load_bus        (is_load_bus),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural cache contents and memory image
    logic             way_v   [2];
    logic             way_tag [2];
    logic             way_idx [2];
    int               exp_victim;
    logic             cur_tag;
    logic             cur_idx;
    logic [WIDTH-1:0] mem_data [8];

    always_comb begin
        hit_0 = way_v[0] && (way_tag[0] == cur_tag) && (way_idx[0] == cur_idx);
        hit_1 = way_v[1] && (way_tag[1] == cur_tag) && (way_idx[1] == cur_idx);
        hit   = hit_0 || hit_1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lookup(input logic t, input logic i);
        for (int w = 0; w < 2; w++) begin
            if (way_v[w] && way_tag[w] == t && way_idx[w] == i) return w;
        end
        return -1;
    endfunction

    // One CPU load from transfer to response; stall/lat < 0 means random
    task automatic run_req(input logic t, input logic i, input logic o,
                           input bit hold, input int stall_force, input int lat_force);
        int   exp_way;
        bit   exp_hit;
        bit   done;
        bit   prev_pending;
        int   cyc;
        int   fill_cyc;
        int   mstate;
        int   lat;
        int   stall;
        int   words;
        logic [LINE_W-1:0] exp_line;

        exp_way  = lookup(t, i);
        exp_hit  = (exp_way >= 0);
        exp_line = {mem_data[{t, i, 1'b0}], mem_data[{t, i, 1'b1}]};

        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid      = 1'b1;
        req_tag        = t;
        req_index      = i;
        req_offset     = o;
        cur_tag        = t;
        cur_idx        = i;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        @(posedge clk);

        done = 0; cyc = 0; fill_cyc = -10; mstate = 0; words = 0; prev_pending = 0; lat = 0;
        stall = (stall_force >= 0) ? stall_force : int'($urandom_range(0, 2));
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_data  = $urandom;
            req_valid      = hold ? 1'b1 : 1'($urandom_range(0, 1));
            req_tag        = 1'($urandom);
            req_index      = 1'($urandom);
            req_offset     = 1'($urandom);

            check("req_ready_busy", 64'(req_ready), 64'd0);
            if (exp_hit) check("hit_no_mem", 64'(mem_req_valid), 64'd0);

            if (is_load_bus != 2'b00) begin
                check("fill_way", 64'(is_load_bus), (exp_victim == 0) ? 64'd2 : 64'd1);
                check("fill_words", 64'(words), 64'd2);
                check("fill_data", (exp_victim == 0) ? line_bus_0 : line_bus_1, exp_line);
                check("fill_tag", 64'({out_tag, out_index}), 64'({t, i}));
                way_v[exp_victim]   = 1'b1;
                way_tag[exp_victim] = t;
                way_idx[exp_victim] = i;
                exp_way    = exp_victim;
                exp_victim = 1 - exp_victim;
                fill_cyc   = cyc;
            end

            if (resp_valid) begin
                check("resp_latency", 64'(cyc), exp_hit ? 64'd1 : 64'(fill_cyc + 1));
                check("resp_way", 64'(control_cache_word), 64'(exp_way));
                check("resp_offset", 64'(control_offset), 64'(o));
                done = 1;
            end

            if (mstate == 0) begin
                if (mem_req_valid) begin
                    check("mem_addr", 64'(mem_req_addr), 64'({t, i, 1'(words)}));
                    if (stall > 0) begin
                        stall--;
                    end else begin
                        mem_req_ready = 1'b1;
                        mstate = 1;
                        lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, 3));
                    end
                end else begin
                    if (prev_pending) check("mem_req_held", 64'(mem_req_valid), 64'd1);
                    if ($urandom_range(0, 3) == 0) mem_resp_valid = 1'b1;
                end
                prev_pending = mem_req_valid && !mem_req_ready;
            end else begin
                check("one_outstanding", 64'(mem_req_valid), 64'd0);
                prev_pending = 0;
                lat--;
                if (lat <= 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_data[{t, i, 1'(words)}];
                    words++;
                    mstate = 0;
                    stall = (stall_force >= 0) ? stall_force : int'($urandom_range(0, 2));
                end
            end

            if (done) begin
                req_valid      = 1'b0;
                mem_resp_valid = 1'b0;
                mem_req_ready  = 1'b0;
            end
        end
        check("resp_timeout", 64'(done), 64'd1);
    endtask

    // Reset while waiting on memory, then a stray response arrives
    task automatic reset_mid_refill();
        logic t;
        logic i;
        t = 1'b0; i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (lookup(1'(k >> 1), 1'(k)) < 0) begin
                t = 1'(k >> 1);
                i = 1'(k);
            end
        end
        @(negedge clk);
        req_valid = 1'b1; req_tag = t; req_index = i; req_offset = 1'b1;
        cur_tag = t; cur_idx = i;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_mem_req", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("rst_pre_wait", 64'(mem_req_valid), 64'd0);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        exp_victim = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_fill", 64'(is_load_bus), 64'd0);
            check("rst_ready", 64'(req_ready), 64'd1);
            check("rst_no_mem", 64'(mem_req_valid), 64'd0);
            check("rst_no_resp", 64'(resp_valid), 64'd0);
            mem_resp_valid = (k < 2);
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_tag = 1'b0; req_index = 1'b0; req_offset = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        cur_tag = 1'b0; cur_idx = 1'b0; exp_victim = 0;
        for (int w = 0; w < 2; w++) begin
            way_v[w] = 1'b0; way_tag[w] = 1'b0; way_idx[w] = 1'b0;
        end
        for (int k = 0; k < 8; k++) mem_data[k] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("post_rst_mem_req", 64'(mem_req_valid), 64'd0);
        check("post_rst_load_bus", 64'(is_load_bus), 64'd0);
        check("post_rst_controls", 64'({control_offset, control_cache_word}), 64'd0);

        run_req(1'b0, 1'b1, 1'b1, 0, 0, 2);   // cold miss into way 0
        run_req(1'b1, 1'b1, 1'b0, 0, 0, -1);  // second miss into way 1
        run_req(1'b0, 1'b1, 1'b1, 0, -1, -1); // hit on the first line
        run_req(1'b1, 1'b0, 1'b1, 0, -1, -1); // third miss back to way 0
        run_req(1'b0, 1'b0, 1'b0, 0, 5, -1);  // memory stalls 5 cycles per word
        run_req(1'b1, 1'b1, 1'b1, 1, -1, -1); // req_valid held through refill
        reset_mid_refill();

        for (int n = 0; n < 60; n++) begin
            run_req(1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
